// File: rtl/shake128_absorb_packer.sv
// SHAKE128 absorb-side packer: 32-bit LE words -> padded 1344-bit rate blocks.
// Optional macro ABSORB_BLK_COUNT_EN adds a saturating accepted-block counter.
module shake128_absorb_packer #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned RATE_WORDS = 42
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [DATA_WIDTH-1:0]            in_data,
   input  logic                             in_last,
   input  logic [2:0]                       in_bytes,
   output logic                             blk_valid,
   input  logic                             blk_ready,
   output logic [RATE_WORDS*DATA_WIDTH-1:0] blk_data,
   output logic                             blk_last,
`ifdef ABSORB_BLK_COUNT_EN
   output logic [15:0]                      blk_count_o,
`endif
   output logic                             busy
);

   localparam int unsigned BLK_W      = RATE_WORDS * DATA_WIDTH;
   localparam int unsigned WORD_BYTES = DATA_WIDTH / 8;
   localparam int unsigned RATE_BYTES = RATE_WORDS * WORD_BYTES;
   localparam int unsigned CNT_W      = $clog2(RATE_WORDS);
   localparam int unsigned PW         = $clog2(RATE_BYTES + 1);

   localparam logic [1:0] ST_FILL = 2'd0;
   localparam logic [1:0] ST_EMIT = 2'd1;
   localparam logic [1:0] ST_PAD  = 2'd2;

   logic [1:0]            r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [BLK_W-1:0]      r_buf;
   logic                  r_last;
   logic                  r_pend;

   logic                  w_hs;
   logic                  w_wrap;
   logic                  w_pad_hit;
   logic [2:0]            w_nbytes;
   logic [DATA_WIDTH-1:0] w_word;
   logic [PW-1:0]         w_pos;
   logic [BLK_W-1:0]      w_fill_buf;
   logic [BLK_W-1:0]      w_pad_blk;

   assign in_ready  = (r_state == ST_FILL);
   assign blk_valid = (r_state == ST_EMIT);
   assign blk_data  = r_buf;
   assign blk_last  = r_last;
   assign busy      = (r_state != ST_FILL) || (r_cnt != '0);

   assign w_hs   = in_valid && (r_state == ST_FILL);
   assign w_wrap = (r_cnt == CNT_W'(RATE_WORDS - 1));

   always_comb begin
      w_nbytes = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
      w_word   = in_data;
      if (in_last) begin
         for (int unsigned b = 0; b < WORD_BYTES; b++) begin
            if (b >= 32'(w_nbytes)) w_word[8*b +: 8] = '0;
         end
      end
      w_pos = PW'({r_cnt, 2'b00}) + PW'(w_nbytes);

      // Slots at and above cnt are still zero, so XOR-ing the pad bytes acts as a set
      // except where 0x1F and 0x80 land on the same final byte (0x9F).
      w_fill_buf = r_buf;
      for (int unsigned w = 0; w < RATE_WORDS; w++) begin
         if (r_cnt == CNT_W'(w)) w_fill_buf[DATA_WIDTH*w +: DATA_WIDTH] = w_word;
      end
      w_pad_hit = in_last && (w_pos < PW'(RATE_BYTES));
      if (w_pad_hit) begin
         for (int unsigned b = 0; b < RATE_BYTES; b++) begin
            if (w_pos == PW'(b)) w_fill_buf[8*b +: 8] = w_fill_buf[8*b +: 8] ^ 8'h1F;
         end
         w_fill_buf[BLK_W-1 -: 8] = w_fill_buf[BLK_W-1 -: 8] ^ 8'h80;
      end

      w_pad_blk              = '0;
      w_pad_blk[7:0]         = 8'h1F;
      w_pad_blk[BLK_W-1 -: 8] = 8'h80;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_FILL;
         r_cnt   <= '0;
         r_buf   <= '0;
         r_last  <= 1'b0;
         r_pend  <= 1'b0;
      end else begin
         case (r_state)
            ST_FILL: begin
               if (w_hs) begin
                  r_buf <= w_fill_buf;
                  if (in_last) begin
                     r_state <= ST_EMIT;
                     r_cnt   <= '0;
                     r_last  <= w_pad_hit;
                     // Message ended exactly on the block boundary: padding needs its own block.
                     r_pend  <= !w_pad_hit;
                  end else if (w_wrap) begin
                     r_state <= ST_EMIT;
                     r_cnt   <= '0;
                     r_last  <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            ST_EMIT: begin
               if (blk_ready) begin
                  r_buf  <= '0;
                  r_last <= 1'b0;
                  if (r_pend) begin
                     r_pend  <= 1'b0;
                     r_state <= ST_PAD;
                  end else begin
                     r_state <= ST_FILL;
                  end
               end
            end
            ST_PAD: begin
               r_buf   <= w_pad_blk;
               r_last  <= 1'b1;
               r_state <= ST_EMIT;
            end
            default: r_state <= ST_FILL;
         endcase
      end
   end

`ifdef ABSORB_BLK_COUNT_EN
   logic [15:0] r_blk_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_blk_count <= '0;
      end else if (blk_valid && blk_ready && (r_blk_count != 16'hFFFF)) begin
         r_blk_count <= r_blk_count + 16'd1;
      end
   end

   assign blk_count_o = r_blk_count;
`endif

endmodule

// File: tb/tb_shake128_absorb_packer.sv
// Scoreboard bench for shake128_absorb_packer: expected blocks come from a byte-level
// sponge padding model; a monitor pops and compares on every accepted block.
module tb_shake128_absorb_packer;

   localparam int RB = 168;

   typedef struct {
      logic [1343:0] data;
      logic          last;
   } blk_t;

   typedef struct {
      logic [31:0] d;
      logic        l;
      logic [2:0]  nb;
   } word_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [31:0]   in_data = '0;
   logic          in_last = 1'b0;
   logic [2:0]    in_bytes = '0;
   logic          blk_valid;
   logic          blk_ready = 1'b0;
   logic [1343:0] blk_data;
   logic          blk_last;
   logic          busy;
`ifdef ABSORB_BLK_COUNT_EN
   logic [15:0]   blk_count_o;
`endif

   int   n_checks = 0;
   int   n_pass = 0;
   int   n_blk = 0;
   int   ready_mode = 0;
   blk_t sb[$];

   always #5 clk = ~clk;

   shake128_absorb_packer #(.DATA_WIDTH(32), .RATE_WORDS(42)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .in_bytes(in_bytes),
      .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
      .blk_last(blk_last),
`ifdef ABSORB_BLK_COUNT_EN
      .blk_count_o(blk_count_o),
`endif
      .busy(busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic finish_run();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   endtask

   task automatic timeout(input string name);
      n_checks++;
      $display("FAIL timeout %s: got no event expected one within budget", name);
      finish_run();
   endtask

   // Sponge padding: msg || 0x1F || 0* || 0x80 over 168-byte blocks (0x1F^0x80 may share a byte).
   function automatic void model_push(input logic [7:0] m[$]);
      int   len = m.size();
      int   nblk = len / RB + 1;
      blk_t e;
      for (int k = 0; k < nblk; k++) begin
         e.data = '0;
         for (int i = 0; i < RB; i++) begin
            if (RB * k + i < len) e.data[8*i +: 8] = m[RB*k + i];
         end
         e.last = (k == nblk - 1);
         if (e.last) begin
            e.data[8*(len % RB) +: 8] = e.data[8*(len % RB) +: 8] ^ 8'h1F;
            e.data[1343 -: 8]         = e.data[1343 -: 8] ^ 8'h80;
         end
         sb.push_back(e);
      end
   endfunction

   task automatic drive_word(input logic [31:0] d, input logic l, input logic [2:0] nb,
                             input bit first);
      int cyc = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      in_bytes = nb;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         cyc++;
         if (cyc > 2000) timeout("in_ready");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = $urandom;
      if (first) check("busy_after_word", busy, 1);
      if (ready_mode == 0 && $urandom_range(0, 3) == 0) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_msg(input logic [7:0] m[$], input bit extra);
      word_t ws[$];
      word_t w;
      int    len = m.size();
      int    nfull = len / 4;
      int    rem = len % 4;
      int    nbody;
      model_push(m);
      nbody = (rem != 0 || len == 0 || extra) ? nfull : nfull - 1;
      for (int i = 0; i < nbody; i++) begin
         w.d  = {m[4*i+3], m[4*i+2], m[4*i+1], m[4*i]};
         w.l  = 1'b0;
         w.nb = 3'($urandom_range(0, 7));
         ws.push_back(w);
      end
      w.d = $urandom;
      w.l = 1'b1;
      if (rem != 0) begin
         for (int b = 0; b < rem; b++) w.d[8*b +: 8] = m[4*nfull + b];
         w.nb = 3'(rem);
      end else if (len == 0 || extra) begin
         w.nb = 3'd0;
      end else begin
         w.d  = {m[len-1], m[len-2], m[len-3], m[len-4]};
         w.nb = 3'($urandom_range(4, 7));
      end
      ws.push_back(w);
      for (int i = 0; i < ws.size(); i++) drive_word(ws[i].d, ws[i].l, ws[i].nb, i == 0);
   endtask

   task automatic send_len(input int len, input bit extra);
      logic [7:0] m[$];
      for (int i = 0; i < len; i++) m.push_back(8'($urandom));
      send_msg(m, extra);
   endtask

   task automatic drain();
      int cyc = 0;
      while (sb.size() != 0) begin
         @(negedge clk);
         cyc++;
         if (cyc > 3000) timeout("drain");
      end
   endtask

   // Ready generator: 0 random, 1 hold low 10 cycles per block, 2 always low.
   initial begin
      int vcnt = 0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: blk_ready = ($urandom_range(0, 3) != 0);
            1: begin
               if (blk_valid) begin
                  vcnt++;
                  blk_ready = (vcnt > 10);
               end else begin
                  vcnt = 0;
                  blk_ready = 1'b0;
               end
            end
            default: blk_ready = 1'b0;
         endcase
      end
   end

   // Monitor
   initial begin
      logic          prev_stall = 1'b0;
      logic [1343:0] prev_data = '0;
      logic          prev_last = 1'b0;
      blk_t          e;
`ifdef ABSORB_BLK_COUNT_EN
      logic [15:0]   exp_count = '0;
`endif
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
`ifdef ABSORB_BLK_COUNT_EN
            exp_count = '0;
`endif
         end else begin
`ifdef ABSORB_BLK_COUNT_EN
            check("blk_count", blk_count_o, exp_count);
`endif
            if (prev_stall) begin
               check("stall_valid_held", blk_valid, 1);
               n_checks++;
               if (blk_data === prev_data && blk_last === prev_last) n_pass++;
               else $display("FAIL stall_data_stable: got changed block expected held block");
            end
            if (blk_valid) check("in_ready_low_in_emit", in_ready, 0);
            if (blk_valid && blk_ready) begin
               n_checks++;
               if (sb.size() == 0) begin
                  $display("FAIL unexpected_block: got block %0d expected none", n_blk);
               end else begin
                  e = sb.pop_front();
                  if (blk_data === e.data && blk_last === e.last) begin
                     n_pass++;
                  end else begin
                     for (int i = 0; i < RB; i++) begin
                        if (blk_data[8*i +: 8] !== e.data[8*i +: 8]) begin
                           $display("FAIL block%0d byte %0d: got %02h expected %02h (last got %0b expected %0b)",
                                    n_blk, i, blk_data[8*i +: 8], e.data[8*i +: 8], blk_last, e.last);
                           break;
                        end
                     end
                     if (blk_data === e.data)
                        $display("FAIL block%0d last: got %0b expected %0b", n_blk, blk_last, e.last);
                  end
               end
               n_blk++;
`ifdef ABSORB_BLK_COUNT_EN
               if (exp_count != 16'hFFFF) exp_count++;
`endif
            end
            prev_stall = blk_valid && !blk_ready;
            prev_data  = blk_data;
            prev_last  = blk_last;
         end
      end
   end

   initial begin
      logic [7:0] m[$];
      int cyc;
      #23;
      check("rst_in_ready", in_ready, 1);
      check("rst_blk_valid", blk_valid, 0);
      check("rst_blk_last", blk_last, 0);
      check("rst_busy", busy, 0);
      check("rst_blk_data_zero", blk_data == '0, 1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      send_len(0, 1'b0);                 // empty message
      m = {8'h61, 8'h62, 8'h63};         // "abc"
      model_push(m);
      drive_word(32'h00636261, 1'b1, 3'd3, 1'b1);
      send_len(167, 1'b0);
      send_len(168, 1'b0);
      send_len(168, 1'b1);
      drain();

      ready_mode = 1;
      send_len(400, 1'b0);               // 100 words, stalled blocks
      drain();

      ready_mode = 0;
      for (int k = 0; k < 16; k++) begin
         if (k % 4 == 0) send_len($urandom_range(160, 176), 1'($urandom_range(0, 1)));
         else send_len($urandom_range(0, 420), 1'($urandom_range(0, 1)));
      end
      drain();

      // Reset while a block is held in EMIT
      ready_mode = 2;
      send_len(3, 1'b0);
      cyc = 0;
      while (!blk_valid) begin
         @(negedge clk);
         cyc++;
         if (cyc > 100) timeout("blk_valid");
      end
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_blk_valid", blk_valid, 0);
      check("rst_mid_blk_last", blk_last, 0);
      check("rst_mid_blk_data_zero", blk_data == '0, 1);
      sb.delete();
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1);
      check("post_rst_busy", busy, 0);
      @(posedge clk);
      #1;
      ready_mode = 0;
      send_len(50, 1'b0);
      send_len(170, 1'b0);
      drain();
      repeat (5) @(negedge clk);
      check("scoreboard_drained", 64'(sb.size()), 0);
      finish_run();
   end

endmodule
